// File: rtl/s27_scan_ctrl.sv
// Scan test controller for the scan-inserted s27 core. It loads the chain, applies
// one capture cycle, unloads and compares the response, and counts failing tests.
module s27_scan_ctrl #(
    parameter int CHAIN_LEN = 3,
    parameter int CNT_W     = 16
) (
    input  logic                 CK,
    input  logic                 RST_N,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] load_vec,
    input  logic [CHAIN_LEN-1:0] exp_vec,
    input  logic                 scan_out,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [CHAIN_LEN-1:0] unload_vec,
    output logic [CNT_W-1:0]     err_cnt
);

    localparam int BIT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        CAPTURE,
        SHIFT_OUT,
        DONE
    } state_t;

    state_t               state;
    logic [BIT_W-1:0]     bit_cnt;
    logic [CHAIN_LEN-1:0] load_sr;
    logic [CHAIN_LEN-1:0] exp_q;
    logic [CHAIN_LEN-1:0] unload_sr;
    logic [CHAIN_LEN-1:0] unload_next;
    logic                 mismatch;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The first bit sampled ends up in the MSB after CHAIN_LEN left shifts.
    assign unload_next = {unload_sr[CHAIN_LEN-2:0], scan_out};
    assign mismatch    = (unload_next != exp_q);

    always_ff @(posedge CK) begin
        if (!RST_N) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            load_sr    <= '0;
            exp_q      <= '0;
            unload_sr  <= '0;
            scan_en    <= 1'b0;
            scan_in    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            unload_vec <= '0;
            err_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // MSB goes out immediately; the rest are queued MSB-first.
                        scan_in <= load_vec[CHAIN_LEN-1];
                        load_sr <= {load_vec[CHAIN_LEN-2:0], 1'b0};
                        exp_q   <= exp_vec;
                        scan_en <= 1'b1;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        state   <= SHIFT_IN;
                    end
                end
                SHIFT_IN: begin
                    if (bit_cnt == LAST_BIT) begin
                        scan_en <= 1'b0;
                        state   <= CAPTURE;
                    end else begin
                        scan_in <= load_sr[CHAIN_LEN-1];
                        load_sr <= {load_sr[CHAIN_LEN-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    scan_en <= 1'b1;
                    scan_in <= 1'b0;
                    bit_cnt <= '0;
                    state   <= SHIFT_OUT;
                end
                SHIFT_OUT: begin
                    unload_sr <= unload_next;
                    if (bit_cnt == LAST_BIT) begin
                        scan_en    <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        unload_vec <= unload_next;
                        fail       <= mismatch;
                        if (mismatch) begin
                            err_cnt <= sat_inc(err_cnt);
                        end
                        state <= DONE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
